button_step_conditioner: RTL and testbench
==========================================

Name: button_step_conditioner

Overview:
- Front-end for the LED-movement stage. Conditions the two raw, bouncy push-buttons (left, right) into clean single-cycle step pulses. The downstream mover consumes these pulses directly.
- Per button: 2-flop synchroniser, then debounce filter, then press-edge detect, then auto-repeat while held.
- The cross-button rule (same-cycle suppression) sits after the per-button logic, so the downstream stage never sees both directions in one cycle.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive cycles the synchronised input must disagree with the debounced level before that level flips (10 ms at 100 MHz). Must be ≥1.
- REPEAT_EN, 1: 1 enables auto-repeat while held; 0 gives exactly one pulse per press.
- REPEAT_DELAY, 50000000: cycles from the first pulse to the first repeat pulse. Must be ≥1.
- REPEAT_PERIOD, 23000000: cycles between subsequent repeat pulses. Must be ≥1.

Ports:
- clk_100mhz  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- btn_left  in  1  raw asynchronous left button, high = pressed
- btn_right  in  1  raw asynchronous right button, high = pressed
- step_left  out  1  one-cycle pulse: move lit LED left
- step_right  out  1  one-cycle pulse: move lit LED right
- left_level  out  1  debounced left button level
- right_level  out  1  debounced right button level

Behaviour:
- Reset (sampled at a clock edge while reset=1):
  - all synchroniser flops, debounced levels, counters and timers clear to 0;
  - FSMs go to IDLE;
  - step_left = step_right = left_level = right_level = 0.
  - Reset mid-press: after reset deasserts, a still-held button is treated as a new press. It produces a pulse after the full debounce latency.
- Synchroniser: two flops per button. Raw input reaches the sync output after 2 edges.
- Debounce, per button:
  - Counter cnt, width ceil(log2(DEBOUNCE_CYCLES+1)).
  - If sync == level: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: level <= sync, cnt <= 0.
  - Else: cnt <= cnt+1.
  - Any glitch shorter than DEBOUNCE_CYCLES restarts the count. The same filter applies to press and release.
- Step FSM, per button. Timer width fits max(REPEAT_DELAY, REPEAT_PERIOD).
  - IDLE: if level=1, then req=1, timer <= 0, go to HOLD.
  - HOLD:
    - level=0: go to IDLE, no req.
    - Else if REPEAT_EN and timer == REPEAT_DELAY-1: req=1, timer <= 0, go to REPEAT.
    - Else: timer++. With REPEAT_EN=0 the FSM stays in HOLD until release.
  - REPEAT:
    - level=0: go to IDLE.
    - Else if timer == REPEAT_PERIOD-1: req=1, timer <= 0.
    - Else: timer++.
  - Release never generates a pulse.
- Output stage (registered):
  - step_left <= req_left & ~req_right; step_right <= req_right & ~req_left.
  - Same-cycle requests cancel each other: neither pulse fires. Each FSM still advances as if its pulse had fired, so its timing is unaffected.
  - Each step is high for exactly 1 cycle per req.
- Latency:
  - Number the first edge that samples raw=1 as edge 1. Level rises at edge DEBOUNCE_CYCLES+2. The step pulse is registered at edge DEBOUNCE_CYCLES+3.
  - First repeat pulse: REPEAT_DELAY cycles after the first pulse.
  - Further repeat pulses: every REPEAT_PERIOD cycles.
- left_level and right_level are the debounced levels, not delayed by the output stage.
- Both buttons are independent except for the same-cycle cancellation.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, REPEAT_EN=1 unless stated):
1. Assert reset 3 cycles with btn_left=1 → all outputs 0 during reset. After release, step_left pulses once, 7 edges after the first post-reset sampling edge; left_level=1.
2. btn_right clean high for 60 cycles → pulses at edges 7, 27, 35, 43, 51, 59, each exactly 1 cycle wide. Release → no pulse; right_level falls 6 edges after release.
3. btn_left bounce 1,0,1,1,0,1 per cycle, then stable high → no pulse until 4 consecutive synchronised highs; exactly one initial pulse.
4. btn_left and btn_right rise on the same edge and hold 10 cycles → step_left=step_right=0 throughout; both levels=1.
5. REPEAT_EN=0, btn_left held 100 cycles → exactly one step_left pulse (edge 7). Release then press again → one more pulse.
6. btn_left held; mid-REPEAT, assert reset 1 cycle → outputs 0 next cycle. Next pulse comes 7 edges after reset deasserts, not on the old repeat schedule.

Source files
------------

// File: rtl/button_step_conditioner.sv
// Button front-end: per-button sync, debounce, press-edge and auto-repeat, then a registered
// output stage that suppresses simultaneous left/right steps.
module button_step_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter bit          REPEAT_EN       = 1'b1,
    parameter int unsigned REPEAT_DELAY    = 50000000,
    parameter int unsigned REPEAT_PERIOD   = 23000000
) (
    input  logic clk_100mhz,
    input  logic reset,
    input  logic btn_left,
    input  logic btn_right,
    output logic step_left,
    output logic step_right,
    output logic left_level,
    output logic right_level
);

    localparam int unsigned CntW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned TmrMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                    : REPEAT_PERIOD;
    localparam int unsigned TmrW   = $clog2(TmrMax + 1);

    localparam logic [CntW-1:0] CntLast    = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TmrW-1:0] DelayLast  = TmrW'(REPEAT_DELAY - 1);
    localparam logic [TmrW-1:0] PeriodLast = TmrW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {StIdle, StHold, StRepeat} state_e;

    logic [1:0] btn_raw;
    logic [1:0] level;
    logic [1:0] req;

    // Index 0 is the left button, index 1 the right button.
    assign btn_raw = {btn_right, btn_left};

    for (genvar b = 0; b < 2; b++) begin : g_btn
        logic [1:0]      sync_q;
        logic            level_q, level_d;
        logic [CntW-1:0] cnt_q, cnt_d;
        state_e          state_q, state_d;
        logic [TmrW-1:0] tmr_q, tmr_d;
        logic            req_d;

        always_ff @(posedge clk_100mhz) begin
            if (reset) begin
                sync_q  <= '0;
                level_q <= 1'b0;
                cnt_q   <= '0;
                state_q <= StIdle;
                tmr_q   <= '0;
            end else begin
                sync_q  <= {sync_q[0], btn_raw[b]};
                level_q <= level_d;
                cnt_q   <= cnt_d;
                state_q <= state_d;
                tmr_q   <= tmr_d;
            end
        end

        // Any disagreement shorter than DEBOUNCE_CYCLES restarts the count.
        always_comb begin
            level_d = level_q;
            cnt_d   = cnt_q;
            if (sync_q[1] == level_q) begin
                cnt_d = '0;
            end else if (cnt_q == CntLast) begin
                level_d = sync_q[1];
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        always_comb begin
            state_d = state_q;
            tmr_d   = tmr_q;
            req_d   = 1'b0;
            case (state_q)
                StIdle: begin
                    if (level_q) begin
                        req_d   = 1'b1;
                        tmr_d   = '0;
                        state_d = StHold;
                    end
                end
                StHold: begin
                    if (!level_q) begin
                        state_d = StIdle;
                    end else if (REPEAT_EN && (tmr_q == DelayLast)) begin
                        req_d   = 1'b1;
                        tmr_d   = '0;
                        state_d = StRepeat;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
                StRepeat: begin
                    if (!level_q) begin
                        state_d = StIdle;
                    end else if (tmr_q == PeriodLast) begin
                        req_d = 1'b1;
                        tmr_d = '0;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        assign level[b] = level_q;
        assign req[b]   = req_d;
    end

    logic step_left_q, step_right_q;

    // Simultaneous requests cancel; the FSMs advance regardless so their timing is kept.
    always_ff @(posedge clk_100mhz) begin
        if (reset) begin
            step_left_q  <= 1'b0;
            step_right_q <= 1'b0;
        end else begin
            step_left_q  <= req[0] & ~req[1];
            step_right_q <= req[1] & ~req[0];
        end
    end

    assign step_left   = step_left_q;
    assign step_right  = step_right_q;
    assign left_level  = level[0];
    assign right_level = level[1];

endmodule

// File: tb/tb_button_step_conditioner.sv
// Directed bench: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, plus a REPEAT_EN=0 copy.
module tb_button_step_conditioner;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn_left = 1'b0, btn_right = 1'b0;
    logic step_left, step_right, left_level, right_level;
    logic btn_left2 = 1'b0, btn_right2 = 1'b0;
    logic step_left2, step_right2, left_level2, right_level2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    button_step_conditioner #(
        .DEBOUNCE_CYCLES(4), .REPEAT_EN(1'b1), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
    ) dut (
        .clk_100mhz (clk),
        .reset      (reset),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .step_left  (step_left),
        .step_right (step_right),
        .left_level (left_level),
        .right_level(right_level)
    );

    button_step_conditioner #(
        .DEBOUNCE_CYCLES(4), .REPEAT_EN(1'b0), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
    ) dut_norep (
        .clk_100mhz (clk),
        .reset      (reset),
        .btn_left   (btn_left2),
        .btn_right  (btn_right2),
        .step_left  (step_left2),
        .step_right (step_right2),
        .left_level (left_level2),
        .right_level(right_level2)
    );

    task automatic check(input string tag, input logic got, input logic exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the edge they reflect.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_chk(input string tag, input logic el, input logic er);
        tick();
        check({tag, "_step_left"}, step_left, el);
        check({tag, "_step_right"}, step_right, er);
    endtask

    task automatic settle(input string tag);
        for (int i = 0; i < 10; i++) tick_chk(tag, 1'b0, 1'b0);
    endtask

    initial begin
        // 1: reset with left held, then the first pulse 7 edges after reset releases
        reset = 1'b1;
        btn_left = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t1_rst_step_left", step_left, 1'b0);
            check("t1_rst_step_right", step_right, 1'b0);
            check("t1_rst_left_level", left_level, 1'b0);
            check("t1_rst_right_level", right_level, 1'b0);
        end
        reset = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick_chk("t1", e == 7, 1'b0);
            if (e == 5) check("t1_level_e5", left_level, 1'b0);
            if (e == 6) check("t1_level_e6", left_level, 1'b1);
        end
        btn_left = 1'b0;
        settle("t1_release");
        check("t1_level_released", left_level, 1'b0);

        // 2: right held 60 cycles: pulses at 7 and every 8 from 27, none on release
        btn_right = 1'b1;
        for (int e = 1; e <= 60; e++) begin
            tick_chk("t2", 1'b0, (e == 7) || (e >= 27 && ((e - 27) % 8) == 0));
            if (e == 6) check("t2_level_e6", right_level, 1'b1);
        end
        btn_right = 1'b0;
        for (int r = 1; r <= 10; r++) begin
            tick_chk("t2_release", 1'b0, 1'b0);
            if (r == 5) check("t2_level_r5", right_level, 1'b1);
            if (r == 6) check("t2_level_r6", right_level, 1'b0);
        end

        // 3: bounce 1,0,1,1,0,1 then steady: level at edge 11, single pulse at 12
        for (int e = 1; e <= 25; e++) begin
            case (e)
                2, 5:    btn_left = 1'b0;
                default: btn_left = 1'b1;
            endcase
            tick_chk("t3", e == 12, 1'b0);
            if (e == 10) check("t3_level_e10", left_level, 1'b0);
            if (e == 11) check("t3_level_e11", left_level, 1'b1);
        end
        btn_left = 1'b0;
        settle("t3_release");

        // 4: both pressed together: requests cancel, levels still rise
        btn_left = 1'b1;
        btn_right = 1'b1;
        for (int e = 1; e <= 10; e++) tick_chk("t4", 1'b0, 1'b0);
        check("t4_left_level", left_level, 1'b1);
        check("t4_right_level", right_level, 1'b1);
        btn_left = 1'b0;
        btn_right = 1'b0;
        settle("t4_release");

        // 5: REPEAT_EN=0 copy: one pulse per press
        btn_left2 = 1'b1;
        for (int e = 1; e <= 100; e++) begin
            tick();
            check("t5_step_left", step_left2, e == 7);
            check("t5_step_right", step_right2, 1'b0);
        end
        btn_left2 = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            check("t5_release", step_left2, 1'b0);
        end
        check("t5_level_released", left_level2, 1'b0);
        btn_left2 = 1'b1;
        for (int e = 1; e <= 15; e++) begin
            tick();
            check("t5_repress", step_left2, e == 7);
        end
        btn_left2 = 1'b0;

        // 6: reset mid-REPEAT restarts the schedule from a fresh press
        btn_left = 1'b1;
        for (int e = 1; e <= 38; e++) begin
            tick_chk("t6", (e == 7) || e == 27 || e == 35, 1'b0);
        end
        reset = 1'b1;
        tick();
        check("t6_rst_step_left", step_left, 1'b0);
        check("t6_rst_left_level", left_level, 1'b0);
        reset = 1'b0;
        for (int r = 1; r <= 12; r++) begin
            tick_chk("t6_after", r == 7, 1'b0);
            if (r == 6) check("t6_level_r6", left_level, 1'b1);
        end
        btn_left = 1'b0;
        settle("t6_release");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
